// File: rtl/mem_if_pkg.sv
// ============================================================================
// mem_if_pkg : shared types and constants for the MEM-stage data port
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int   DATA_W     = 32;
  localparam int   BE_W       = 4;
  localparam int   WORD_BYTES = 4;

  localparam logic RSP_OK     = 1'b0;
  localparam logic RSP_ERR    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// data_mem_responder_if : request/response channels of the data port
// Revision              : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [BE_W-1:0]   req_be_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

`default_nettype wire

// File: rtl/sp_ram_be.sv
// ============================================================================
// sp_ram_be : synchronous single-port RAM, per-byte write enable, registered read
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_ram_be
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic              clk_i,
  input  wire logic              en_i,
  input  wire logic              we_i,
  input  wire logic [AW-1:0]     addr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [BE_W-1:0]   be_i,
  output logic      [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : single-outstanding load/store responder with wait states
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input wire logic             clk_i,
  input wire logic             rst_n_i,
  data_mem_responder_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int WW    = ADDR_W - OFF_W;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]        state;
  logic [7:0]        cnt;
  logic              we_q;
  logic [AW-1:0]     widx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;

  logic [WW-1:0]     req_word;
  logic              hi_nz;
  logic              addr_err;
  logic              access;
  logic [DATA_W-1:0] ram_q;

  assign req_word = bus.req_addr_i[ADDR_W-1:OFF_W];

  // Depth is a power of two, so out-of-range means any word-index bit above AW is set.
  generate
    if (WW > AW) begin : g_range
      assign hi_nz = |req_word[WW-1:AW];
    end else begin : g_full
      assign hi_nz = 1'b0;
    end
  endgenerate

  assign addr_err = (|bus.req_addr_i[OFF_W-1:0]) | hi_nz;
  assign access   = (state == S_WAIT) && (cnt == 8'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= RSP_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            we_q    <= bus.req_we_i;
            widx_q  <= req_word[AW-1:0];
            wdata_q <= bus.req_wdata_i;
            be_q    <= bus.req_be_i;
            err_q   <= addr_err ? RSP_ERR : RSP_OK;
            cnt     <= 8'(WAIT_CYCLES);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) state <= S_RESP;
          else             cnt   <= cnt - 8'd1;
        end
        S_RESP: begin
          if (bus.rsp_ready_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sp_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (access && (err_q == RSP_OK)),
    .we_i    (we_q),
    .addr_i  (widx_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (ram_q)
  );

  // RAM read register only updates on a load access, so it stays stable through RESP.
  assign bus.req_ready_o = (state == S_IDLE);
  assign bus.rsp_valid_o = (state == S_RESP);
  assign bus.rsp_err_o   = (state == S_RESP) ? err_q : RSP_OK;
  assign bus.rsp_rdata_o = ((state == S_RESP) && !we_q && (err_q == RSP_OK)) ? ram_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : randomized bench with a word-array reference model
// Revision              : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;
  import mem_if_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;
  int          cur = 0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(32)) bus0 ();
  data_mem_responder_if #(.ADDR_W(32)) bus1 ();

  assign bus0.req_valid_i = v0;
  assign bus0.req_we_i    = req_we;
  assign bus0.req_addr_i  = req_addr;
  assign bus0.req_wdata_i = req_wdata;
  assign bus0.req_be_i    = req_be;
  assign bus0.rsp_ready_i = rsp_ready & (cur == 0);
  assign bus1.req_valid_i = v1;
  assign bus1.req_we_i    = req_we;
  assign bus1.req_addr_i  = req_addr;
  assign bus1.req_wdata_i = req_wdata;
  assign bus1.req_be_i    = req_be;
  assign bus1.rsp_ready_i = rsp_ready & (cur == 1);

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_W(32)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

  logic        w_req_ready, w_rsp_valid, w_rsp_err;
  logic [31:0] w_rsp_rdata;
  assign w_req_ready = (cur == 1) ? bus1.req_ready_o : bus0.req_ready_o;
  assign w_rsp_valid = (cur == 1) ? bus1.rsp_valid_o : bus0.rsp_valid_o;
  assign w_rsp_err   = (cur == 1) ? bus1.rsp_err_o   : bus0.rsp_err_o;
  assign w_rsp_rdata = (cur == 1) ? bus1.rsp_rdata_o : bus0.rsp_rdata_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (dut%0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  task automatic set_valid(input logic val);
    v0 = (cur == 0) ? val : 1'b0;
    v1 = (cur == 1) ? val : 1'b0;
  endtask

  // Drives one transaction from an idle point (#1 after an edge); request inputs
  // and rsp_ready are scrambled while the responder is busy.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    set_valid(1'b1);
    check_eq("req_ready_idle", {31'd0, w_req_ready}, 32'd1);
    @(posedge clk); #1;
    lat = 0;
    while (!w_rsp_valid && lat < 300) begin
      check_eq("req_ready_busy", {31'd0, w_req_ready}, 32'd0);
      req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    rd = w_rsp_rdata;
    er = w_rsp_err;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      check_eq("bp_valid", {31'd0, w_rsp_valid}, 32'd1);
      check_eq("bp_rdata", w_rsp_rdata, rd);
      check_eq("bp_err", {31'd0, w_rsp_err}, {31'd0, er});
      check_eq("bp_req_ready", {31'd0, w_req_ready}, 32'd0);
    end
    set_valid(1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("done_valid", {31'd0, w_rsp_valid}, 32'd0);
    check_eq("done_ready", {31'd0, w_req_ready}, 32'd1);
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_er, er;
    int          lat, w;
    exp_er = (addr[1:0] != 2'd0) || ((addr >> 2) >= 32'(DEPTH));
    exp_rd = '0;
    if (!exp_er) begin
      w = int'(addr >> 2);
      if (!we) exp_rd = mdl[cur][w];
      else
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[cur][w][8*b +: 8] = wdata[8*b +: 8];
    end
    txn(we, addr, wdata, be, hold, rd, er, lat);
    check_eq("latency", 32'(lat), (cur == 1) ? 32'd1 : 32'd3);
    check_eq("rdata", rd, exp_rd);
    check_eq("err", {31'd0, er}, {31'd0, exp_er});
  endtask

  task automatic random_phase(input int n);
    logic [31:0] rd, addr;
    int          w;
    for (int k = 0; k < n; k++) begin
      w = $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0:       addr = (32'(w) << 2) | 32'($urandom_range(1, 3));
        1:       addr = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
        default: addr = 32'(w) << 2;
      endcase
      run(1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3), rd);
    end
  endtask

  initial begin
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_ready0", {31'd0, bus0.req_ready_o}, 32'd1);
    check_eq("rst_valid0", {31'd0, bus0.rsp_valid_o}, 32'd0);
    check_eq("rst_rdata0", bus0.rsp_rdata_o, 32'd0);
    check_eq("rst_err0", {31'd0, bus0.rsp_err_o}, 32'd0);
    check_eq("rst_ready1", {31'd0, bus1.req_ready_o}, 32'd1);
    check_eq("rst_valid1", {31'd0, bus1.rsp_valid_o}, 32'd0);

    for (int c = 0; c < 2; c++) begin
      cur = c; #1;
      for (int i = 0; i < 16; i++) run(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, rd);
    end
    cur = 0; #1;

    run(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    run(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check_eq("load_deadbeef", rd, 32'hDEADBEEF);
    run(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd);
    run(1'b0, 32'h10, 32'h0, 4'hF, 0, rd);
    check_eq("partial_store", rd, 32'hDE22BE44);
    run(1'b0, 32'h13, 32'h0, 4'hF, 0, rd);
    run(1'b1, 32'(DEPTH) << 2, 32'hFFFFFFFF, 4'hF, 0, rd);
    run(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
    run(1'b1, 32'h14, 32'h0, 4'h0, 0, rd);
    run(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);

    // Reset while the store to 0x20 is still counting down.
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_eq("midrst_ready", {31'd0, bus0.req_ready_o}, 32'd1);
    check_eq("midrst_valid", {31'd0, bus0.rsp_valid_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);

    random_phase(60);
    cur = 1; #1;
    run(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    random_phase(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
